skewed_act_buffer: RTL

Parametrised, double-buffered activation feeder for the systolic array.
- Host logic writes one tile of activations per row into a fill bank while the other bank drains into the array's row inputs.
- Row r is delayed by r cycles, producing the diagonal wavefront the array requires.
- Generalises the fixed, file-loaded input buffer: writable storage, run-time tile length, ping-pong banking and explicit start/done handshakes.

---
 rtl/skewed_act_buffer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/skewed_act_buffer.sv
// Ping-pong activation store: the host fills one bank while the other drains
// into the systolic array, row r delayed by r cycles to form the wavefront.
module skewed_act_buffer #(
  parameter int ROWS   = 4,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int RW = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [RW-1:0]          wr_row,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DWIDTH-1:0]      wr_data,
  input  logic                   wr_commit,
  input  logic [AW:0]            wr_len,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             bank_ready,
  output logic [ROWS-1:0]        o_valid,
  output logic [ROWS*DWIDTH-1:0] o_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [AW:0]   LEN_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   LEN_MAX    = (AW+1)'(DEPTH);
  localparam logic [RW-1:0] FLUSH_DONE = RW'(ROWS-2);
  localparam logic [RW-1:0] FLUSH_END  = RW'(ROWS-1);

  state_t                  state_r;
  logic [AW-1:0]           cnt_r;
  logic [RW-1:0]           fcnt_r;
  logic                    fill_bank_r;
  logic                    drain_bank_r;
  logic [1:0]              bank_ready_r;
  logic [AW:0]             len_r [2];
  logic                    busy_r;
  logic                    done_r;
  logic                    err_r;
  logic [ROWS-1:0]         o_valid_r;
  logic [ROWS*DWIDTH-1:0]  o_data_r;
  logic [ROWS-1:1]         en_pipe_r;
  logic [AW-1:0]           addr_pipe_r [ROWS-1:1];
  logic [DWIDTH-1:0]       mem_r [2][ROWS][DEPTH];

  logic                    fill_free_s;
  logic                    len_ok_s;
  logic                    commit_ok_s;
  logic                    write_ok_s;
  logic                    start_ok_s;
  logic                    stream_last_s;
  logic                    flush_end_s;
  logic [AW:0]             last_addr_s;
  logic [1:0]              set_mask_s;
  logic [1:0]              clr_mask_s;

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign bank_ready = bank_ready_r;
  assign o_valid    = o_valid_r;
  assign o_data     = o_data_r;

  // Qualify host write/commit requests and the drain-side FSM events.
  always_comb begin
    fill_free_s   = ~bank_ready_r[fill_bank_r];
    len_ok_s      = (wr_len >= LEN_ONE) && (wr_len <= LEN_MAX);
    commit_ok_s   = wr_commit && fill_free_s && len_ok_s;
    write_ok_s    = wr_en && fill_free_s;
    start_ok_s    = (state_r == IDLE) && start && bank_ready_r[drain_bank_r];
    last_addr_s   = len_r[drain_bank_r] - LEN_ONE;
    stream_last_s = (state_r == STREAM) && ({1'b0, cnt_r} == last_addr_s);
    flush_end_s   = (state_r == FLUSH) && (fcnt_r == FLUSH_END);
    set_mask_s    = commit_ok_s ? (2'b01 << fill_bank_r) : 2'b00;
    clr_mask_s    = flush_end_s ? (2'b01 << drain_bank_r) : 2'b00;
  end

  // Host write port into the fill bank; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (write_ok_s) begin
      mem_r[fill_bank_r][wr_row][wr_addr] <= wr_data;
    end
  end

  // Bank bookkeeping and the IDLE/STREAM/FLUSH drain sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      fcnt_r       <= '0;
      fill_bank_r  <= 1'b0;
      drain_bank_r <= 1'b0;
      bank_ready_r <= 2'b00;
      len_r[0]     <= '0;
      len_r[1]     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      err_r        <= wr_commit && !commit_ok_s;
      done_r       <= (state_r == FLUSH) && (fcnt_r == FLUSH_DONE);
      // Commit and completion always target different banks, so both apply.
      bank_ready_r <= (bank_ready_r | set_mask_s) & ~clr_mask_s;
      if (commit_ok_s) begin
        len_r[fill_bank_r] <= wr_len;
        fill_bank_r        <= ~fill_bank_r;
      end
      if (flush_end_s) begin
        drain_bank_r <= ~drain_bank_r;
      end
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_r <= STREAM;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
          end
        end
        STREAM: begin
          cnt_r <= cnt_r + AW'(1);
          if (stream_last_s) begin
            state_r <= FLUSH;
            fcnt_r  <= '0;
          end
        end
        FLUSH: begin
          fcnt_r <= fcnt_r + RW'(1);
          if (flush_end_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Row-enable/address skew pipeline and registered, zero-when-idle read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_r <= '0;
      o_data_r  <= '0;
      en_pipe_r <= '0;
      for (int r = 1; r < ROWS; r++) begin
        addr_pipe_r[r] <= '0;
      end
    end else begin
      en_pipe_r[1]   <= (state_r == STREAM);
      addr_pipe_r[1] <= cnt_r;
      for (int r = 2; r < ROWS; r++) begin
        en_pipe_r[r]   <= en_pipe_r[r-1];
        addr_pipe_r[r] <= addr_pipe_r[r-1];
      end
      o_valid_r[0]         <= (state_r == STREAM);
      o_data_r[DWIDTH-1:0] <= (state_r == STREAM) ? mem_r[drain_bank_r][0][cnt_r] : '0;
      for (int r = 1; r < ROWS; r++) begin
        o_valid_r[r]                 <= en_pipe_r[r];
        o_data_r[r*DWIDTH +: DWIDTH] <= en_pipe_r[r] ? mem_r[drain_bank_r][r][addr_pipe_r[r]] : '0;
      end
    end
  end

endmodule
